ai_matmul_responder: RTL and testbench

// - Responder (coprocessor) side of the EX-stage AI start/busy/done handshake; the core pulses start for AI opcode 3'b001.
// - Latches two packed NxN signed matrices and computes C = A x B sequentially, one output element per cycle.
// - Reports busy/done and holds the full result for the core's EX/MEM capture.

---
 rtl/ai_pkg.sv | 17 +
 rtl/ai_dot_lane.sv | 36 +++
 rtl/ai_matmul_responder.sv | 111 +++++++++++
 tb/tb_ai_matmul_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ai_pkg.sv
// Shared definitions for the AI coprocessor responders: default geometry,
// opcode constants and the responder FSM encoding.
package ai_pkg;

  localparam int AI_N   = 4;
  localparam int AI_DW  = 16;
  localparam int AI_ACC = 32;

  localparam logic [2:0] AI_OP_MATMUL = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } ai_state_e;

endpackage

// File: rtl/ai_dot_lane.sv
// Combinational signed dot product of row 'row' of A with column 'col' of B,
// accumulated modulo 2^ACC.
module ai_dot_lane
  import ai_pkg::*;
#(
  parameter int N   = AI_N,
  parameter int DW  = AI_DW,
  parameter int ACC = AI_ACC,
  parameter int IW  = $clog2(AI_N)
) (
  input  logic [N*N*DW-1:0] a,
  input  logic [N*N*DW-1:0] b,
  input  logic [IW-1:0]     row,
  input  logic [IW-1:0]     col,
  output logic [ACC-1:0]    dot
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACC-1:0]  acc;

  // NOTE: every variable written here gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int k = 0; k < N; k++) begin
      prod = $signed(a[(int'(row) * N + k) * DW +: DW]) *
             $signed(b[(k * N + int'(col)) * DW +: DW]);
      // The signed size cast sign-extends the product; the sum simply wraps.
      acc  = acc + ACC'(prod);
    end
  end

  assign dot = acc;

endmodule

// File: rtl/ai_matmul_responder.sv
// Coprocessor side of the start/busy/done handshake: latches A and B, then
// produces one element of C = A x B per cycle into a held result register.
module ai_matmul_responder
  import ai_pkg::*;
#(
  parameter int N   = AI_N,
  parameter int DW  = AI_DW,
  parameter int ACC = AI_ACC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N*N*DW-1:0]  matrix_a,
  input  logic [N*N*DW-1:0]  matrix_b,
  output logic               busy,
  output logic               done,
  output logic [N*N*ACC-1:0] result
);

  localparam int IW   = $clog2(N);
  localparam int IDXW = $clog2(N * N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N * N - 1);

  ai_state_e         state, state_next;
  logic [IDXW-1:0]   idx;
  logic [N*N*DW-1:0] a_q, b_q;
  logic              accept, write_en;
  logic              busy_next, done_next;
  logic [IW-1:0]     row, col;
  logic [ACC-1:0]    dot;

  assign row = IW'(int'(idx) / N);
  assign col = IW'(int'(idx) % N);

  ai_dot_lane #(.N(N), .DW(DW), .ACC(ACC), .IW(IW)) u_lane (
    .a   (a_q),
    .b   (b_q),
    .row (row),
    .col (col),
    .dot (dot)
  );

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Abort dominates in every state, including a simultaneous start.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    write_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = COMPUTE;
          accept     = 1'b1;
        end
      end
      COMPUTE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          write_en = 1'b1;
          if (idx == LAST_IDX) state_next = DONE;
        end
      end
      DONE: begin
        if (!abort && start) begin
          state_next = COMPUTE;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == COMPUTE);
    done_next = (state_next == DONE);
  end

  // NOTE: the wide operand and result registers are reset explicitly because
  // the core may read result straight out of reset and expects zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      idx    <= '0;
    end else if (accept) begin
      a_q    <= matrix_a;
      b_q    <= matrix_b;
      result <= '0;
      idx    <= '0;
    end else if (write_en) begin
      result[int'(idx) * ACC +: ACC] <= dot;
      idx                            <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ai_matmul_responder.sv
// Self-checking bench: fixed table vectors, randomized runs against a plain
// arithmetic model, and hand-written back-to-back, abort and reset sequences.
module tb_ai_matmul_responder;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int ACC = 32;
  localparam int AW  = N * N * DW;
  localparam int RW  = N * N * ACC;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] matrix_a, matrix_b;
  logic          busy, done;
  logic [RW-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ai_matmul_responder #(.N(N), .DW(DW), .ACC(ACC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: C(i,j) = sum_k A(i,k)*B(k,j) in wide integers, kept mod 2^ACC.
  function automatic logic [RW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [RW-1:0] c;
    longint        s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'($signed(a[(i * N + k) * DW +: DW])) *
               longint'($signed(b[(k * N + j) * DW +: DW]));
        c[(i * N + j) * ACC +: ACC] = s[ACC-1:0];
      end
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] m;
    logic [DW-1:0] v;
    m = '0;
    for (int e = 0; e < N * N; e++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'h7FFF;
        1:       v = 16'h8000;
        default: v = DW'($urandom);
      endcase
      m[e * DW +: DW] = v;
    end
    return m;
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen.
  // lat counts rising edges after the accept edge.
  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit noise,
                        output int lat, output int busy_cnt, output bit overlap);
    lat      = 0;
    busy_cnt = 0;
    overlap  = 1'b0;
    matrix_a = a;
    matrix_b = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (busy && done) overlap = 1'b1;
      if (done || lat >= 100) break;
      if (busy) busy_cnt++;
      matrix_a = rand_mat();
      matrix_b = rand_mat();
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a1, b1, a2, b2;
    logic [RW-1:0] partial, held;
    int            lat, bcnt;
    bit            ovl, seen;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    matrix_a = '0; matrix_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", RW'(busy), '0);
    check("reset_done", RW'(done), '0);
    check("reset_result", result, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int e = 0; e < N * N; e++) begin
      vecs[0].a[e * DW +: DW]    = ((e / N) == (e % N)) ? 16'd1 : 16'd0;
      vecs[0].b[e * DW +: DW]    = 16'(e + 1);
      vecs[0].exp[e * ACC +: ACC] = 32'(e + 1);
      vecs[1].a[e * DW +: DW]    = 16'hFFFF;
      vecs[1].b[e * DW +: DW]    = 16'hFFFF;
      vecs[1].exp[e * ACC +: ACC] = 32'd4;
      vecs[2].a[e * DW +: DW]    = 16'h7FFF;
      vecs[2].b[e * DW +: DW]    = 16'h7FFF;
      vecs[2].exp[e * ACC +: ACC] = 32'hFFFC0004;
    end

    for (int v = 0; v < 3; v++) begin
      run_op(vecs[v].a, vecs[v].b, 1'b0, lat, bcnt, ovl);
      check($sformatf("tab%0d_latency", v), RW'(lat), RW'(16));
      check($sformatf("tab%0d_busy_cycles", v), RW'(bcnt), RW'(16));
      check($sformatf("tab%0d_busy_done_overlap", v), RW'(ovl), '0);
      check($sformatf("tab%0d_result", v), result, vecs[v].exp);
      @(negedge clk);
      check($sformatf("tab%0d_done_pulse", v), RW'(done), '0);
    end

    // Random operands with start noise during COMPUTE, which must be ignored.
    for (int r = 0; r < 6; r++) begin
      a1 = rand_mat();
      b1 = rand_mat();
      run_op(a1, b1, 1'b1, lat, bcnt, ovl);
      check($sformatf("rnd%0d_latency", r), RW'(lat), RW'(16));
      check($sformatf("rnd%0d_result", r), result, model(a1, b1));
      @(negedge clk);
    end

    // Back-to-back: start held high through the done cycle.
    a1 = rand_mat(); b1 = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
    matrix_a = a1; matrix_b = b1; start = 1'b1;
    @(negedge clk);
    matrix_a = a2; matrix_b = b2;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("b2b_first_latency", RW'(lat), RW'(16));
    check("b2b_first_result", result, model(a1, b1));
    @(negedge clk);
    check("b2b_reaccept_busy", RW'(busy), RW'(1));
    check("b2b_reaccept_done", RW'(done), '0);
    check("b2b_zeroed", result, '0);
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    start = 1'b0;
    check("b2b_second_latency", RW'(lat), RW'(16));
    check("b2b_second_result", result, model(a2, b2));
    @(negedge clk);
    check("b2b_idle_after", RW'({busy, done}), '0);

    // Abort during the 5th COMPUTE cycle: elements 0..3 remain, rest stay zero.
    a1 = rand_mat(); b1 = rand_mat();
    partial = model(a1, b1) & {{(RW - 4 * ACC){1'b0}}, {(4 * ACC){1'b1}}};
    matrix_a = a1; matrix_b = b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", RW'(busy), '0);
    check("abort_done", RW'(done), '0);
    check("abort_partial", result, partial);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    check("abort_quiet", RW'(seen), '0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", RW'(busy), '0);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    check("abort_start_quiet", RW'(seen), '0);
    check("abort_hold", result, partial);

    // Asynchronous reset during the 8th COMPUTE cycle.
    a1 = rand_mat(); b1 = rand_mat();
    held = model(a1, b1);
    matrix_a = a1; matrix_b = b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", RW'(busy), '0);
    check("rst_done", RW'(done), '0);
    check("rst_result", result, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", RW'({busy, done}), '0);
    run_op(a1, b1, 1'b0, lat, bcnt, ovl);
    check("rst_clean_latency", RW'(lat), RW'(16));
    check("rst_clean_result", result, held);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
